// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
// Demand-actuated phase controller for a 4-way junction. North-south vehicles,
// east-west vehicles and pedestrians compete for the junction. Green time is
// actuated between MIN_GREEN and MAX_GREEN. Yellow and all-red clearance
// follow each green, and requesters are granted round-robin from all-red.
// Every output is a registered decode of the state being entered, so the
// lights always agree with the state register.
module traffic_phase_scheduler #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 2,
  parameter int WALK      = 5,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic [2:0] n_lights,
  output logic [2:0] s_lights,
  output logic [2:0] e_lights,
  output logic [2:0] w_lights,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR   = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    PED  = 3'd5,
    BAD6 = 3'd6,
    BAD7 = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    LAST_NS  = 2'd0,
    LAST_EW  = 2'd1,
    LAST_PED = 2'd2
  } last_t;

  localparam logic [CNT_W-1:0] MIN_M1  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK - 1);

  localparam logic [2:0] LT_GRN = 3'b001;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_RED = 3'b100;

  state_t           r_state;
  state_t           w_next_state;
  state_t           w_grant;
  last_t            r_last;
  last_t            w_next_last;
  logic [CNT_W-1:0] r_timer;
  logic             r_ns_pend;
  logic             r_ew_pend;
  logic             r_ped_pend;
  logic             w_state_chg;
  logic             w_in_green;

  function automatic logic [2:0] ns_lights_of(input state_t s);
    case (s)
      NS_G:    return LT_GRN;
      NS_Y:    return LT_YEL;
      default: return LT_RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_lights_of(input state_t s);
    case (s)
      EW_G:    return LT_GRN;
      EW_Y:    return LT_YEL;
      default: return LT_RED;
    endcase
  endfunction

  assign w_state_chg = (w_next_state != r_state);
  assign w_in_green  = (r_state == NS_G) || (r_state == EW_G);

  // Round-robin grant out of all-red: first pending requester after last;
  // with nothing pending, alternate between the two vehicle greens.
  always_comb begin
    w_grant = NS_G;
    case (r_last)
      LAST_NS: begin
        if (r_ew_pend)       w_grant = EW_G;
        else if (r_ped_pend) w_grant = PED;
        else if (r_ns_pend)  w_grant = NS_G;
        else                 w_grant = EW_G;
      end
      LAST_EW: begin
        if (r_ped_pend)      w_grant = PED;
        else if (r_ns_pend)  w_grant = NS_G;
        else if (r_ew_pend)  w_grant = EW_G;
        else                 w_grant = NS_G;
      end
      default: begin
        if (r_ns_pend)       w_grant = NS_G;
        else if (r_ew_pend)  w_grant = EW_G;
        else if (r_ped_pend) w_grant = PED;
        else                 w_grant = NS_G;
      end
    endcase
  end

  // Next-state and last-served selection.
  always_comb begin
    w_next_state = r_state;
    w_next_last  = r_last;
    case (r_state)
      NS_G: begin
        if ((r_ew_pend || r_ped_pend) &&
            (((r_timer >= MIN_M1) && !ns_req) || (r_timer >= MAX_M1)))
          w_next_state = NS_Y;
      end
      NS_Y: begin
        if (r_timer == YEL_M1) begin
          w_next_state = AR;
          w_next_last  = LAST_NS;
        end
      end
      EW_G: begin
        if ((r_ns_pend || r_ped_pend) &&
            (((r_timer >= MIN_M1) && !ew_req) || (r_timer >= MAX_M1)))
          w_next_state = EW_Y;
      end
      EW_Y: begin
        if (r_timer == YEL_M1) begin
          w_next_state = AR;
          w_next_last  = LAST_EW;
        end
      end
      PED: begin
        if (r_timer == WALK_M1) begin
          w_next_state = AR;
          w_next_last  = LAST_PED;
        end
      end
      AR: begin
        if (r_timer == AR_M1) w_next_state = w_grant;
      end
      default: w_next_state = AR;
    endcase
  end

  // State and last-served registers.
  always_ff @(posedge clk) begin
    if (rst_a) begin
      r_state <= NS_G;
      r_last  <= LAST_NS;
    end else begin
      r_state <= w_next_state;
      r_last  <= w_next_last;
    end
  end

  // Phase timer: restarts on every state change, holds at MAX_GREEN-1 in green.
  always_ff @(posedge clk) begin
    if (rst_a)                           r_timer <= '0;
    else if (w_state_chg)                r_timer <= '0;
    else if (w_in_green && r_timer >= MAX_M1) r_timer <= MAX_M1;
    else                                 r_timer <= r_timer + CNT_W'(1);
  end

  // Pending latches: set outside own service state, cleared on entry to it.
  always_ff @(posedge clk) begin
    if (rst_a) begin
      r_ns_pend  <= 1'b0;
      r_ew_pend  <= 1'b0;
      r_ped_pend <= 1'b0;
    end else begin
      r_ns_pend  <= (w_state_chg && w_next_state == NS_G) ? 1'b0 :
                    (r_ns_pend  || (ns_req  && r_state != NS_G));
      r_ew_pend  <= (w_state_chg && w_next_state == EW_G) ? 1'b0 :
                    (r_ew_pend  || (ew_req  && r_state != EW_G));
      r_ped_pend <= (w_state_chg && w_next_state == PED)  ? 1'b0 :
                    (r_ped_pend || (ped_req && r_state != PED));
    end
  end

  // Registered output decode of the state being entered.
  always_ff @(posedge clk) begin
    if (rst_a) begin
      n_lights <= LT_GRN;
      s_lights <= LT_GRN;
      e_lights <= LT_RED;
      w_lights <= LT_RED;
      walk     <= 1'b0;
      phase    <= NS_G;
    end else begin
      n_lights <= ns_lights_of(w_next_state);
      s_lights <= ns_lights_of(w_next_state);
      e_lights <= ew_lights_of(w_next_state);
      w_lights <= ew_lights_of(w_next_state);
      walk     <= (w_next_state == PED);
      phase    <= w_next_state;
    end
  end

endmodule
